fifo_pack_reader: RTL and testbench

Read-side companion to the width-converting `easy_fifo`. It drains a frame of single-word entries from the FIFO using the FIFO's `request` / `out_valid` / `empty` handshake. It packs the words into PACK_SIZE-lane vectors and presents each vector downstream on a valid/ready stream with a lane-keep mask and a last-beat flag. It sits between the FIFO output and wide consumers such as the matrix and vector compute stages.

---
 rtl/fifo_pack_reader.sv | 151 +++++++++++++++
 tb/tb_fifo_pack_reader.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pack_reader.sv
// fifo_pack_reader: drains a frame of FIFO words and packs them
// into PACK_SIZE-lane beats on a valid/ready stream.
module fifo_pack_reader #(
  parameter int DATAWIDTH = 192,
  parameter int PACK_SIZE = 4,
  parameter int LEN_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [LEN_WIDTH-1:0]           frame_len,
  output logic                           fifo_request,
  input  logic [DATAWIDTH-1:0]           fifo_dout,
  input  logic                           fifo_out_valid,
  input  logic                           fifo_empty,
  output logic [DATAWIDTH*PACK_SIZE-1:0] m_data,
  output logic [PACK_SIZE-1:0]           m_keep,
  output logic                           m_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           busy,
  output logic                           done
);

  localparam int LANE_W = $clog2(PACK_SIZE);
  localparam int SLOT_W = LANE_W + 1;
  localparam int BUF_W  = DATAWIDTH * PACK_SIZE;

  localparam logic [SLOT_W-1:0] SLOT_TOP =
    SLOT_W'(PACK_SIZE - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE =
    LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_SEND
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [BUF_W-1:0]     buf_q, buf_d;
  logic [PACK_SIZE-1:0] keep_q, keep_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;

  logic [LANE_W-1:0]    lane;
  logic                 final_word;
  logic                 lane_full;

  // The empty flag is only observed by external checkers.
  logic                 unused_empty;
  assign unused_empty = fifo_empty;

  assign lane       = slot_q[LANE_W-1:0];
  assign final_word = (rem_q <= LEN_ONE);
  assign lane_full  = (slot_q == SLOT_TOP);

  // Next-state and datapath updates for the fill/send sequence.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    slot_d  = slot_q;
    buf_d   = buf_q;
    keep_d  = keep_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (frame_len == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d   = frame_len;
            slot_d  = '0;
            buf_d   = '0;
            keep_d  = '0;
            last_d  = 1'b0;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (fifo_out_valid) begin
          for (int k = 0; k < PACK_SIZE; k++) begin
            if (lane == LANE_W'(k)) begin
              buf_d[k*DATAWIDTH +: DATAWIDTH] = fifo_dout;
              keep_d[k] = 1'b1;
            end
          end
          slot_d = slot_q + SLOT_W'(1);
          if (rem_q != '0) begin
            rem_d = rem_q - LEN_ONE;
          end
          if (final_word || lane_full) begin
            last_d  = final_word;
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (m_ready) begin
          buf_d  = '0;
          keep_d = '0;
          slot_d = '0;
          last_d = 1'b0;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      slot_q  <= '0;
      buf_q   <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      slot_q  <= slot_d;
      buf_q   <= buf_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign fifo_request = (state_q == S_FILL);
  assign m_valid      = (state_q == S_SEND);
  assign busy         = (state_q != S_IDLE);
  assign m_data       = buf_q;
  assign m_keep       = keep_q;
  assign m_last       = last_q;
  assign done         = done_q;

endmodule

// File: tb/tb_fifo_pack_reader.sv
// tb_fifo_pack_reader: randomized and directed bench with a
// frame-level reference model of the packing stream.
module tb_fifo_pack_reader;

  localparam int DW = 192;
  localparam int P  = 4;
  localparam int LW = 16;
  localparam int BW = DW * P;

  typedef struct {
    logic [BW-1:0] d;
    logic [P-1:0]  k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic          fifo_request;
  logic [DW-1:0] fifo_dout;
  logic          fifo_out_valid;
  logic          fifo_empty;
  logic [BW-1:0] m_data;
  logic [P-1:0]  m_keep;
  logic          m_last;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [0:4095];
  int            rd_ptr = 0;
  int            wr_ptr = 0;
  logic          allow = 1'b0;
  logic          spur = 1'b0;

  int total = 0;
  int bad = 0;

  beat_t q[$];
  beat_t log_q[$];
  bit    mbusy = 1'b0;
  bit    exp_done = 1'b0;
  bit    zchk = 1'b0;
  bit    hold = 1'b0;
  logic [BW-1:0] hd;
  logic [P-1:0]  hk;
  logic          hl;
  int    fbase = 0;
  int    flen_m = 0;

  fifo_pack_reader #(
    .DATAWIDTH(DW),
    .PACK_SIZE(P),
    .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .frame_len(frame_len),
    .fifo_request(fifo_request),
    .fifo_dout(fifo_dout),
    .fifo_out_valid(fifo_out_valid),
    .fifo_empty(fifo_empty),
    .m_data(m_data),
    .m_keep(m_keep),
    .m_last(m_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // FIFO model: pops the head whenever it answers a request.
  assign fifo_empty = (rd_ptr >= wr_ptr);
  assign fifo_dout  = mem[rd_ptr % 4096];
  assign fifo_out_valid =
    (fifo_request && !fifo_empty && allow) ||
    (!fifo_request && spur);

  always @(posedge clk)
    if (fifo_request && fifo_out_valid)
      rd_ptr <= rd_ptr + 1;

  task automatic chk(input string nm,
                     input logic [BW-1:0] a,
                     input logic [BW-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seq(input int first, input int n);
    for (int i = 0; i < n; i++)
      mem[(rd_ptr + i) % 4096] = DW'(first + i);
    wr_ptr = rd_ptr + n;
  endtask

  task automatic load_rand(input int n);
    for (int i = 0; i < n; i++)
      mem[(rd_ptr + i) % 4096] = {$urandom(), $urandom(),
        $urandom(), $urandom(), $urandom(), $urandom()};
    wr_ptr = rd_ptr + n;
  endtask

  task automatic pulse_start(input int len);
    start = 1'b1;
    frame_len = LW'(len);
    tick();
    start = 1'b0;
  endtask

  // mode 0: steady, 1: toggle FIFO supply, 2: random noise
  task automatic run_idle(input int maxc, input int mode);
    int c;
    c = 0;
    while (mbusy && c < maxc) begin
      if (mode == 1) allow = ~allow;
      if (mode == 2) begin
        allow   = ($urandom_range(0, 2) != 0);
        m_ready = ($urandom_range(0, 2) != 0);
        spur    = $urandom_range(0, 1);
        start   = ($urandom_range(0, 7) == 0);
        frame_len = LW'($urandom_range(0, 9));
      end
      tick();
      c++;
    end
    start = 1'b0;
    spur = 1'b0;
    if (mbusy) begin
      total++;
      bad++;
      $display("FAIL timeout got=%0d want<%0d", c, maxc);
    end
    m_ready = 1'b1;
    allow = 1'b1;
    tick();
    tick();
  endtask

  // Compare process: checks what the last edge produced, then
  // predicts the effect of the coming edge from the inputs.
  always @(negedge clk) begin
    beat_t b;
    beat_t nb;
    int lane;
    if (zchk) begin
      chk("rst_req", fifo_request, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_last", m_last, 0);
      chk("rst_keep", m_keep, 0);
      chk("rst_data", m_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      zchk = 1'b0;
    end
    chk("done", done, exp_done);
    chk("busy", busy, mbusy);
    chk("request", fifo_request, mbusy && !m_valid);
    if (hold) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, hd);
      chk("hold_keep", m_keep, hk);
      chk("hold_last", m_last, hl);
    end
    if (done)
      chk("pops", rd_ptr - fbase, flen_m);
    if (rst) begin
      q.delete();
      mbusy = 1'b0;
      exp_done = 1'b0;
      hold = 1'b0;
      zchk = 1'b1;
    end else begin
      exp_done = 1'b0;
      if (start && !mbusy) begin
        fbase = rd_ptr;
        flen_m = int'(frame_len);
        if (frame_len == '0) begin
          exp_done = 1'b1;
        end else begin
          mbusy = 1'b1;
          nb.d = '0;
          nb.k = '0;
          nb.l = 1'b0;
          for (int i = 0; i < flen_m; i++) begin
            lane = i % P;
            nb.d[lane*DW +: DW] = mem[(fbase + i) % 4096];
            nb.k[lane] = 1'b1;
            nb.l = (i == flen_m - 1);
            if (lane == P - 1 || nb.l) begin
              q.push_back(nb);
              nb.d = '0;
              nb.k = '0;
            end
          end
        end
      end
      if (m_valid && m_ready) begin
        chk("beat_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          b = q.pop_front();
          chk("beat_data", m_data, b.d);
          chk("beat_keep", m_keep, b.k);
          chk("beat_last", m_last, b.l);
          nb.d = m_data;
          nb.k = m_keep;
          nb.l = m_last;
          log_q.push_back(nb);
          if (b.l) begin
            mbusy = 1'b0;
            exp_done = 1'b1;
          end
        end
      end
      hold = m_valid && !m_ready;
      hd = m_data;
      hk = m_keep;
      hl = m_last;
    end
  end

  initial begin
    int c;
    int r0;
    logic [BW-1:0] lit;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Full beats with a latency probe and an ignored restart.
    m_ready = 1'b1;
    allow = 1'b1;
    load_seq(1, 8);
    log_q.delete();
    r0 = rd_ptr;
    pulse_start(8);
    c = 0;
    while (!m_valid && c < 20) begin
      tick();
      c++;
    end
    chk("first_valid_latency", c, P);
    start = 1'b1;
    frame_len = LW'(3);
    tick();
    start = 1'b0;
    run_idle(100, 0);
    chk("full_pops", rd_ptr - r0, 8);
    chk("full_beats", log_q.size(), 2);
    if (log_q.size() == 2) begin
      lit = {192'd4, 192'd3, 192'd2, 192'd1};
      chk("full_b0_data", log_q[0].d, lit);
      chk("full_b0_keep", log_q[0].k, 4'b1111);
      chk("full_b0_last", log_q[0].l, 0);
      lit = {192'd8, 192'd7, 192'd6, 192'd5};
      chk("full_b1_data", log_q[1].d, lit);
      chk("full_b1_keep", log_q[1].k, 4'b1111);
      chk("full_b1_last", log_q[1].l, 1);
    end

    // Partial final beat.
    load_seq(1, 6);
    log_q.delete();
    pulse_start(6);
    run_idle(100, 0);
    chk("part_beats", log_q.size(), 2);
    if (log_q.size() == 2) begin
      lit = {192'd0, 192'd0, 192'd6, 192'd5};
      chk("part_b1_data", log_q[1].d, lit);
      chk("part_b1_keep", log_q[1].k, 4'b0011);
      chk("part_b1_last", log_q[1].l, 1);
    end

    // FIFO supply toggling every cycle.
    load_seq(100, 8);
    pulse_start(8);
    run_idle(200, 1);

    // Backpressure with stray valids outside FILL.
    load_seq(1, 8);
    m_ready = 1'b0;
    pulse_start(8);
    c = 0;
    while (!m_valid && c < 20) begin
      tick();
      c++;
    end
    r0 = rd_ptr;
    spur = 1'b1;
    repeat (5) tick();
    spur = 1'b0;
    chk("bp_no_pops", rd_ptr, r0);
    m_ready = 1'b1;
    run_idle(100, 0);

    // Zero-length start.
    pulse_start(0);
    tick();
    tick();

    // Reset mid-frame, with start held alongside reset.
    load_seq(1, 16);
    r0 = rd_ptr;
    pulse_start(8);
    c = 0;
    while (rd_ptr != r0 + 2 && c < 20) begin
      tick();
      c++;
    end
    allow = 1'b0;
    rst = 1'b1;
    start = 1'b1;
    frame_len = LW'(4);
    tick();
    rst = 1'b0;
    start = 1'b0;
    tick();
    tick();
    allow = 1'b1;
    log_q.delete();
    pulse_start(4);
    run_idle(100, 0);
    chk("rst_beats", log_q.size(), 1);
    if (log_q.size() == 1) begin
      lit = {192'd6, 192'd5, 192'd4, 192'd3};
      chk("rst_b0_data", log_q[0].d, lit);
      chk("rst_b0_keep", log_q[0].k, 4'b1111);
      chk("rst_b0_last", log_q[0].l, 1);
    end

    // Random frames under random supply and backpressure.
    for (int f = 0; f < 50; f++) begin
      c = $urandom_range(0, 13);
      load_rand(c);
      pulse_start(c);
      run_idle(600, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
